// File: rtl/twiddle81_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// twiddle81_pkg : shared constants and types for the 81-point twiddle sequencer
// rev 1.0
// ----------------------------------------------------------------------------
package twiddle81_pkg;

  localparam int N81    = 81;
  localparam int R1_DEF = 9;
  localparam int R2_DEF = 9;
  localparam int ADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] k1;
    logic [3:0] n2;
    logic       last;
    logic       frame_last;
  } sb_t;

endpackage
`default_nettype wire

// File: rtl/twiddle81_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// twiddle81_if : ROM address handshake plus ROM-aligned sideband
// rev 1.0
// ----------------------------------------------------------------------------
interface twiddle81_if;
  import twiddle81_pkg::*;

  logic [ADDR_W-1:0] tw_addr;
  logic              tw_valid;
  logic              tw_ready;
  logic              sb_valid;
  logic [3:0]        sb_k1;
  logic [3:0]        sb_n2;
  logic              sb_last;
  logic              sb_frame_last;

  modport master (
    output tw_addr, tw_valid, sb_valid, sb_k1, sb_n2, sb_last, sb_frame_last,
    input  tw_ready
  );

  modport slave (
    input  tw_addr, tw_valid, sb_valid, sb_k1, sb_n2, sb_last, sb_frame_last,
    output tw_ready
  );

endinterface
`default_nettype wire

// File: rtl/twiddle81_sb_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// twiddle81_sb_align : delays valid + sideband by TW_FF cycles (0 or 1)
// rev 1.0
// ----------------------------------------------------------------------------
module twiddle81_sb_align
  import twiddle81_pkg::*;
#(
  parameter int TW_FF = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  sb_t  in_sb,
  output logic out_valid,
  output sb_t  out_sb
);

  generate
    if (TW_FF == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_sb    = in_sb;
    end else begin : g_reg
      sb_t  r_sb;
      logic r_valid;

      // No enable: the ROM output register also loads every clock.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_sb    <= '0;
        end else begin
          r_valid <= in_valid;
          r_sb    <= in_sb;
        end
      end

      assign out_valid = r_valid;
      assign out_sb    = r_sb;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/twiddle81_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// twiddle81_sequencer : walks W81^(n2*k1) ROM addresses for N 81-sample frames
// rev 1.0
// ----------------------------------------------------------------------------
module twiddle81_sequencer
  import twiddle81_pkg::*;
#(
  parameter int TW_FF = 0,
  parameter int R1    = R1_DEF,
  parameter int R2    = R2_DEF,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             inverse,
  input  logic [FRM_W-1:0] num_frames,
  output logic             busy,
  output logic             done,
  twiddle81_if.master      tw
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_k1;
  logic [3:0]        r_n2;
  logic [ADDR_W-1:0] r_acc;
  logic [FRM_W-1:0]  r_frame;
  logic [FRM_W-1:0]  r_nf;
  logic              r_inv;
  logic              r_done;

  logic              w_done_nxt;
  logic              w_valid;
  logic              w_load;
  logic              w_fire;
  logic              w_last;
  logic              w_frame_last;
  logic [ADDR_W-1:0] w_addr;
  sb_t               w_sb;
  sb_t               w_sb_out;
  logic              w_sb_valid;

  assign w_last       = (r_k1 == 4'(R1 - 1)) && (r_n2 == 4'(R2 - 1));
  assign w_frame_last = w_last && (r_frame == (r_nf - FRM_W'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_valid     = 1'b0;
    w_load      = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          if (num_frames == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        w_valid = 1'b1;
        // Abort outranks a same-cycle fire: nothing advances.
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (tw.tw_ready) begin
          w_fire = 1'b1;
          if (w_frame_last) begin
            if (TW_FF != 0) begin
              w_state_nxt = FLUSH;
            end else begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        w_state_nxt = IDLE;
        w_done_nxt  = !abort;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_k1    <= '0;
      r_n2    <= '0;
      r_acc   <= '0;
      r_frame <= '0;
      r_nf    <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_k1    <= '0;
        r_n2    <= '0;
        r_acc   <= '0;
        r_frame <= '0;
        r_nf    <= num_frames;
        r_inv   <= inverse;
      end else if (w_fire) begin
        if (r_n2 == 4'(R2 - 1)) begin
          r_n2  <= '0;
          r_acc <= '0;
          if (r_k1 == 4'(R1 - 1)) begin
            r_k1    <= '0;
            r_frame <= r_frame + FRM_W'(1);
          end else begin
            r_k1 <= r_k1 + 4'd1;
          end
        end else begin
          r_n2  <= r_n2 + 4'd1;
          r_acc <= r_acc + {3'b000, r_k1};
        end
      end
    end
  end

  // acc = n2*k1 never exceeds 64, so 81-acc cannot underflow.
  assign w_addr      = (r_inv && (r_acc != '0)) ? (ADDR_W'(N81) - r_acc) : r_acc;
  assign tw.tw_addr  = (r_state == RUN) ? w_addr : '0;
  assign tw.tw_valid = w_valid;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;

  assign w_sb.k1         = r_k1;
  assign w_sb.n2         = r_n2;
  assign w_sb.last       = w_last;
  assign w_sb.frame_last = w_frame_last;

  twiddle81_sb_align #(
    .TW_FF (TW_FF)
  ) u_sb_align (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_fire),
    .in_sb     (w_sb),
    .out_valid (w_sb_valid),
    .out_sb    (w_sb_out)
  );

  assign tw.sb_valid      = w_sb_valid;
  assign tw.sb_k1         = w_sb_out.k1;
  assign tw.sb_n2         = w_sb_out.n2;
  assign tw.sb_last       = w_sb_out.last;
  assign tw.sb_frame_last = w_sb_out.frame_last;

endmodule
`default_nettype wire

// File: tb/tb_twiddle81_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_twiddle81_sequencer : TW_FF=0 and TW_FF=1 instances against an entry-list model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_twiddle81_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, inverse, ready;
  logic [7:0] num_frames;
  logic       busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  twiddle81_if if0();
  twiddle81_if if1();
  assign if0.tw_ready = ready;
  assign if1.tw_ready = ready;

  twiddle81_sequencer #(.TW_FF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inverse(inverse),
    .num_frames(num_frames), .busy(busy0), .done(done0), .tw(if0)
  );

  twiddle81_sequencer #(.TW_FF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .inverse(inverse),
    .num_frames(num_frames), .busy(busy1), .done(done1), .tw(if1)
  );

  logic       d_busy[2], d_done[2], d_tv[2], d_sbv[2], d_last[2], d_fl[2];
  logic [6:0] d_addr[2];
  logic [3:0] d_k1[2], d_n2[2];
  assign d_busy[0] = busy0;            assign d_busy[1] = busy1;
  assign d_done[0] = done0;            assign d_done[1] = done1;
  assign d_tv[0]   = if0.tw_valid;     assign d_tv[1]   = if1.tw_valid;
  assign d_addr[0] = if0.tw_addr;      assign d_addr[1] = if1.tw_addr;
  assign d_sbv[0]  = if0.sb_valid;     assign d_sbv[1]  = if1.sb_valid;
  assign d_k1[0]   = if0.sb_k1;        assign d_k1[1]   = if1.sb_k1;
  assign d_n2[0]   = if0.sb_n2;        assign d_n2[1]   = if1.sb_n2;
  assign d_last[0] = if0.sb_last;      assign d_last[1] = if1.sb_last;
  assign d_fl[0]   = if0.sb_frame_last; assign d_fl[1]  = if1.sb_frame_last;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s (ff%0d) at cyc %0d: got %0d want %0d", nm, inst, cyc, got, want);
    end
  endtask

  // Entry p of a run: frame-local index e, k1 = e/9, n2 = e%9, address = k1*n2 (negated mod 81 for IFFT).
  function automatic int exp_addr(input int p, input bit inv);
    int e, a;
    e = p % 81;
    a = (e / 9) * (e % 9);
    if (inv && a != 0) a = 81 - a;
    return a;
  endfunction

  // Model: a run is just a pointer into the list of 81*num_frames entries.
  bit m_run[2], m_flush[2], m_done[2], m_inv[2];
  int m_ptr[2], m_total[2];
  bit m_pv, m_pfl;
  int m_pp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] <= 0; m_flush[i] <= 0; m_done[i] <= 0; m_inv[i] <= 0;
        m_ptr[i] <= 0; m_total[i] <= 0;
      end
      m_pv <= 0; m_pfl <= 0; m_pp <= 0;
    end else begin
      m_pv  <= m_run[1] && ready && !abort;
      m_pp  <= m_ptr[1];
      m_pfl <= (m_ptr[1] == m_total[1] - 1);
      for (int i = 0; i < 2; i++) begin
        m_done[i] <= 0;
        if (m_run[i]) begin
          if (abort) m_run[i] <= 0;
          else if (ready) begin
            if (m_ptr[i] == m_total[i] - 1) begin
              m_run[i] <= 0;
              if (i == 1) m_flush[i] <= 1; else m_done[i] <= 1;
            end else m_ptr[i] <= m_ptr[i] + 1;
          end
        end else if (m_flush[i]) begin
          m_flush[i] <= 0;
          m_done[i]  <= !abort;
        end else if (start && !abort) begin
          if (num_frames == 0) m_done[i] <= 1;
          else begin
            m_run[i] <= 1; m_ptr[i] <= 0; m_inv[i] <= inverse;
            m_total[i] <= 81 * int'(num_frames);
          end
        end
      end
    end
  end

  int done_cnt[2], done_cyc[2], sbv_cnt[2], last_cnt[2], fl_cnt[2];
  int alog[400];
  int nlog;
  bit e_v, e_fl;
  int e_p;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, d_busy[i], m_run[i] | m_flush[i]);
        chk("done", i, d_done[i], m_done[i]);
        chk("tw_valid", i, d_tv[i], m_run[i]);
        chk("tw_addr", i, d_addr[i], m_run[i] ? exp_addr(m_ptr[i], m_inv[i]) : 0);
        if (i == 0) begin
          e_v = m_run[0] && ready && !abort; e_p = m_ptr[0];
          e_fl = (m_ptr[0] == m_total[0] - 1);
        end else begin
          e_v = m_pv; e_p = m_pp; e_fl = m_pfl;
        end
        chk("sb_valid", i, d_sbv[i], e_v);
        if (e_v) begin
          chk("sb_k1", i, d_k1[i], (e_p % 81) / 9);
          chk("sb_n2", i, d_n2[i], e_p % 9);
          chk("sb_last", i, d_last[i], (e_p % 81) == 80);
          chk("sb_frame_last", i, d_fl[i], e_fl);
        end
        if (d_done[i] === 1'b1) begin done_cnt[i]++; done_cyc[i] = cyc; end
        if (d_sbv[i] === 1'b1) begin
          sbv_cnt[i]++;
          if (d_last[i] === 1'b1) last_cnt[i]++;
          if (d_fl[i] === 1'b1) fl_cnt[i]++;
        end
      end
      if (d_tv[0] === 1'b1 && ready && !abort && nlog < 400) begin
        alog[nlog] = int'(d_addr[0]);
        nlog++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; done_cyc[i] = 0; sbv_cnt[i] = 0; last_cnt[i] = 0; fl_cnt[i] = 0;
    end
    nlog = 0;
  endtask

  int start_cyc;

  // mode: 0 = ready high, 1 = ready 1,0,0,1 pattern, 2 = random ready
  task automatic do_run(input int nf, input bit inv, input int mode,
                        input int abort_at, input int restart_at);
    int n, bound;
    bit ab_done;
    clr_counts();
    num_frames = 8'(nf); inverse = inv; start = 1'b1; ready = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
    num_frames = 8'($urandom);
    inverse = 1'($urandom);
    n = 0; ab_done = 0;
    bound = nf * 81 * 6 + 50;
    while ((m_run[0] || m_run[1] || m_flush[1]) && n < bound) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (n % 4 == 0) || (n % 4 == 3);
        default: ready = ($urandom % 4) != 0;
      endcase
      abort = (abort_at >= 0) && !ab_done && m_run[0] && (m_ptr[0] == abort_at);
      if (abort) ab_done = 1;
      start = (restart_at >= 0) && m_run[0] && (m_ptr[0] == restart_at);
      tick();
      n++;
    end
    abort = 1'b0; start = 1'b0;
    chk("run_in_bound", 0, n < bound, 1);
    tick();
    tick();
  endtask

  task automatic chk_outputs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_busy"}, i, d_busy[i], 0);
      chk({tag, "_done"}, i, d_done[i], 0);
      chk({tag, "_tw_valid"}, i, d_tv[i], 0);
      chk({tag, "_tw_addr"}, i, d_addr[i], 0);
      chk({tag, "_sb"}, i, {d_sbv[i], d_k1[i], d_n2[i], d_last[i], d_fl[i]}, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; inverse = 1'b0;
    num_frames = 8'd0; ready = 1'b0;
    clr_counts();
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic forward frame, ready held high
    do_run(1, 0, 0, -1, -1);
    for (int i = 0; i < 2; i++) begin
      chk("basic_sb_count", i, sbv_cnt[i], 81);
      chk("basic_done_count", i, done_cnt[i], 1);
      chk("basic_last_count", i, last_cnt[i], 1);
      chk("basic_frame_last_count", i, fl_cnt[i], 1);
    end
    chk("basic_done_latency", 0, done_cyc[0] - start_cyc, 81);
    chk("basic_done_latency", 1, done_cyc[1] - start_cyc, 82);
    chk("basic_fire_count", 0, nlog, 81);
    chk("basic_addr_k1_1_n2_0", 0, alog[9], 0);
    chk("basic_addr_k1_1_n2_8", 0, alog[17], 8);
    chk("basic_addr_k1_2_n2_8", 0, alog[26], 16);
    chk("basic_addr_final", 0, alog[80], 64);

    // Inverse frame
    do_run(1, 1, 0, -1, -1);
    chk("inv_addr_entry0", 0, alog[0], 0);
    chk("inv_addr_k1_1_n2_1", 0, alog[10], 80);
    chk("inv_addr_k1_1_n2_8", 0, alog[17], 73);
    chk("inv_addr_final", 0, alog[80], 17);

    // Backpressure 1,0,0,1
    do_run(1, 0, 1, -1, -1);
    chk("bp_sb_count", 1, sbv_cnt[1], 81);
    chk("bp_done_count", 1, done_cnt[1], 1);

    // Three frames with random backpressure
    do_run(3, 0, 2, -1, -1);
    for (int i = 0; i < 2; i++) begin
      chk("multi_sb_count", i, sbv_cnt[i], 243);
      chk("multi_last_count", i, last_cnt[i], 3);
      chk("multi_frame_last_count", i, fl_cnt[i], 1);
      chk("multi_done_count", i, done_cnt[i], 1);
    end

    // Zero frames
    do_run(0, 0, 0, -1, -1);
    for (int i = 0; i < 2; i++) begin
      chk("zero_done_count", i, done_cnt[i], 1);
      chk("zero_done_latency", i, done_cyc[i] - start_cyc, 0);
      chk("zero_sb_count", i, sbv_cnt[i], 0);
    end

    // Start while running is ignored
    do_run(1, 1, 0, -1, 50);
    chk("restart_sb_count", 0, sbv_cnt[0], 81);
    chk("restart_done_count", 1, done_cnt[1], 1);

    // Abort at entry 40
    do_run(2, 0, 0, 40, -1);
    for (int i = 0; i < 2; i++) begin
      chk("abort_done_count", i, done_cnt[i], 0);
      chk("abort_sb_count", i, sbv_cnt[i], 40);
    end

    // Start and abort together from IDLE
    clr_counts();
    num_frames = 8'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("start_abort_busy", 0, busy0, 0);
    chk("start_abort_done_count", 1, done_cnt[1], 0);

    do_run(1, 0, 0, -1, -1);
    chk("after_abort_first_addr", 0, alog[1], 0);
    chk("after_abort_sb_count", 1, sbv_cnt[1], 81);

    // Reset mid-frame
    num_frames = 8'd1; inverse = 1'b0; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_run(1, 1, 2, -1, -1);
    chk("post_reset_first_addr", 0, alog[0], 0);
    chk("post_reset_sb_count", 0, sbv_cnt[0], 81);

    // Randomised runs
    for (int r = 0; r < 6; r++) begin
      int nf;
      nf = $urandom_range(1, 2);
      do_run(nf, 1'($urandom), 2,
             ($urandom % 2) ? $urandom_range(0, nf * 81 - 1) : -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/twiddle81_sequencer.md
Name: twiddle81_sequencer

Overview:
- Address sequencer for the 81-entry twiddle ROM used by the 81-point (9x9) DFT in the PUSCH FFT path.
- On `start`, walks the inter-stage twiddle pattern W81^(n2*k1) for a programmed number of 81-sample frames.
- Drives the ROM address with a valid/ready handshake.
- Emits index/last sideband aligned to the ROM output for either ROM latency setting (TW_FF = 0 or 1).

Parameters:
- TW_FF, 0, ROM output-register setting. 0 = combinational ROM, 1 = ROM output registered. Sets sideband alignment delay (0 or 1 cycle).
- R1, 9, outer-loop radix (k1 range 0..R1-1).
- R2, 9, inner-loop radix (n2 range 0..R2-1); R1*R2 = 81 fixed.
- FRM_W, 8, width of frame count.

Ports:
- clk  in  1  master clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, starts sequence; ignored while busy
- abort  in  1  synchronous abort; returns to IDLE, no done pulse
- inverse  in  1  sampled at start; 1 = conjugate twiddles (IFFT)
- num_frames  in  FRM_W  frames to generate, sampled at start
- busy  out  1  high from cycle after accepted start until done/abort
- done  out  1  one-cycle pulse after last address accepted
- tw_addr  out  7  ROM address (to ROM addr)
- tw_valid  out  1  tw_addr valid
- tw_ready  in  1  downstream accepts; fire = tw_valid & tw_ready
- sb_valid  out  1  ROM output valid this cycle (fire delayed TW_FF cycles)
- sb_k1  out  4  k1 of current ROM output
- sb_n2  out  4  n2 of current ROM output
- sb_last  out  1  last entry of a frame (k1=R1-1, n2=R2-1)
- sb_frame_last  out  1  last entry of last frame

Behaviour:
- Reset (rst_n=0, async):
  - FSM goes to IDLE; all counters clear.
  - busy=0, done=0, tw_valid=0, tw_addr=0.
  - All sb_* outputs = 0.
- FSM states IDLE, RUN, FLUSH:
  - IDLE with start=1:
    - num_frames=0 → done pulse next cycle, stay IDLE, no addresses issued.
    - Otherwise latch inverse and num_frames; k1=0, n2=0, acc=0, frame=0; go to RUN.
  - RUN: tw_valid=1 and tw_addr is combinational from registered state.
    - Without fire: all state held, so tw_addr is stable under stall (TW_FF=1 ROM then re-registers the same value).
    - On fire, n2 increments and acc += k1.
    - When n2 = R2-1: n2 → 0, acc → 0, k1 increments.
    - When additionally k1 = R1-1: k1 → 0 and frame increments.
    - Fire on the last entry of the last frame → FLUSH if TW_FF=1, else done pulse and IDLE.
  - FLUSH (TW_FF=1 only): one cycle, tw_valid=0; done pulses on exit to IDLE.
- Address arithmetic:
  - acc is 7-bit and equals n2*k1; max 64 < 81, so no wrap.
  - tw_addr = acc when inverse=0.
  - tw_addr = (acc==0) ? 0 : 81-acc when inverse=1.
  - Entry order: k1-major, n2-minor, 81 entries per frame.
- Sideband:
  - TW_FF=0: sb_* combinational from current state, sb_valid = fire.
  - TW_FF=1: sb_* registered from fire-cycle values every clock (no enable), so they align with the ROM's registered output.
- Throughput: one address per cycle when tw_ready is held high; done asserts 81*num_frames cycles after start (+1 with TW_FF=1 for the flush).
- Boundary and conflict rules:
  - start while busy: ignored.
  - abort has priority over fire in the same cycle: no state advance, no sb_valid from that cycle's fire, no done.
  - abort in IDLE: no effect.
  - start and abort in the same cycle from IDLE: abort wins, start ignored.
  - tw_ready low for any number of cycles: nothing lost, tw_addr held.
  - Reset asserted mid-frame: immediate return to reset values; next start begins at k1=0, n2=0.

Decomposition:
- Shared FFT package holds:
  - constants N81=81, R1/R2 defaults, address width 7;
  - state enum {IDLE, RUN, FLUSH};
  - sideband struct {k1, n2, last, frame_last}.
- One natural sub-module, `twiddle81_sb_align`: TW_FF-parameterised delay of valid plus sideband (pass-through or one register stage).
- The ROM is instantiated by the parent, not inside this block.

Test Plan:
- Basic sequence: start, num_frames=1, inverse=0, tw_ready=1, TW_FF=0.
  - Expect 81 fires with addresses 0×9, then 0,1,..,8, then 0,2,..,16, …, last 64.
  - sb_last on entry 81; done at cycle 82; busy low afterwards.
- Inverse: inverse=1, num_frames=1.
  - Row k1=1 gives 0,80,79,..,73; final address 81-64=17; entry 0 gives address 0.
- Backpressure: tw_ready toggles 1,0,0,1 pattern, TW_FF=1.
  - tw_addr stable during stall; sb_valid is exactly fire delayed 1 cycle.
  - sb_k1/sb_n2 match the ROM output entry; 81 sb_valid pulses total.
- Multi-frame: num_frames=3.
  - 243 fires; sb_last on entries 81, 162, 243; sb_frame_last only on entry 243.
  - Single done pulse after FLUSH (TW_FF=1).
- Zero frames and ignored start: num_frames=0 → done next cycle, tw_valid never high. Start during RUN → no restart, count unchanged.
- Abort and reset mid-operation:
  - abort at entry 40 → IDLE next cycle, no done; a new start restarts at address 0.
  - rst_n low mid-frame → all outputs 0 asynchronously.
